// File: rtl/timer_cmd_serializer.sv
// Purpose : queues 4-bit delay requests and serializes each as start pattern 1101 + delay (MSB-first) to the pattern timer.
// Latency : push into an empty FIFO while idle -> first serial bit two cycles later; ack one cycle after timer_done is seen.
// Backpres: req_ready drops while the request FIFO is full; new requests are accepted in every state, including GAP.
//
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_delay request handshake;
//        ser_data serial stream to the timer, timer_done/timer_ack timer handshake;
//        cmp_valid/cmp_delay/cmp_err completion report; err_timeout sticky; busy activity.
// Optional watchdog in WAIT_DONE: define TIMER_CMD_WDOG_EN (enables TIMEOUT parameter,
// cmp_err and err_timeout); without it both error outputs are tied low.
module timer_cmd_serializer #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 4
`ifdef TIMER_CMD_WDOG_EN
    ,
    parameter int TIMEOUT    = 20000
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_delay,
    output logic       ser_data,
    input  logic       timer_done,
    output logic       timer_ack,
    output logic       cmp_valid,
    output logic [3:0] cmp_delay,
    output logic       cmp_err,
    output logic       err_timeout,
    output logic       busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_DONE, ACK, GAP} state_t;

    state_t          state;
    logic [3:0]      fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [7:0]      shift_reg;
    logic [2:0]      bit_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            push;
    logic            pop;

`ifdef TIMER_CMD_WDOG_EN
    localparam logic [14:0] WD_LAST = 15'(TIMEOUT - 1);
    logic [14:0]     wd_cnt;
`else
    assign cmp_err     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Occupancy is registered, so req_ready never depends on req_valid.
    assign req_ready = (count != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    // Storage carries no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_delay;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            ser_data  <= 1'b0;
            timer_ack <= 1'b0;
            cmp_valid <= 1'b0;
            cmp_delay <= '0;
`ifdef TIMER_CMD_WDOG_EN
            wd_cnt      <= '0;
            cmp_err     <= 1'b0;
            err_timeout <= 1'b0;
`endif
        end else begin
            // Pulses and the serial line default low; only SEND drives data.
            ser_data  <= 1'b0;
            timer_ack <= 1'b0;
            cmp_valid <= 1'b0;
`ifdef TIMER_CMD_WDOG_EN
            cmp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= {4'b1101, fifo_mem[rd_ptr]};
                        cmp_delay <= fifo_mem[rd_ptr];
                        bit_cnt   <= '0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    ser_data  <= shift_reg[7];
                    shift_reg <= {shift_reg[6:0], 1'b0};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= WAIT_DONE;
`ifdef TIMER_CMD_WDOG_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                WAIT_DONE: begin
                    // timer_done wins over a watchdog expiry on the same cycle.
                    if (timer_done) begin
                        state     <= ACK;
                        timer_ack <= 1'b1;
                        cmp_valid <= 1'b1;
                    end
`ifdef TIMER_CMD_WDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        state       <= GAP;
                        gap_cnt     <= '0;
                        cmp_valid   <= 1'b1;
                        cmp_err     <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 15'd1;
                    end
`endif
                end
                ACK: begin
                    state   <= GAP;
                    gap_cnt <= '0;
                end
                GAP: begin
                    // Zeros here flush the timer's pattern shifter before the next frame.
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_cmd_serializer.sv
// Purpose : randomized self-checking bench for timer_cmd_serializer against a frame-level reference model.
// Latency : n/a (testbench).
// Backpres: drives req_valid randomly and honours req_ready; emulates the timer's done behaviour.
module tb_timer_cmd_serializer;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;
`ifdef TIMER_CMD_WDOG_EN
    localparam int TMO   = 50;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_delay;
    logic       ser_data;
    logic       timer_done;
    logic       timer_ack;
    logic       cmp_valid;
    logic [3:0] cmp_delay;
    logic       cmp_err;
    logic       err_timeout;
    logic       busy;

    always #5 clk = ~clk;

    timer_cmd_serializer #(
        .DEPTH(DEPTH),
        .GAP_CYCLES(GAP)
`ifdef TIMER_CMD_WDOG_EN
        ,
        .TIMEOUT(TMO)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_delay(req_delay),
        .ser_data(ser_data),
        .timer_done(timer_done),
        .timer_ack(timer_ack),
        .cmp_valid(cmp_valid),
        .cmp_delay(cmp_delay),
        .cmp_err(cmp_err),
        .err_timeout(err_timeout),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;
    int pushes = 0;

    // Reference model state: accepted delays in order, decoded frame, timer schedule.
    logic [3:0] exp_q[$];
    bit         in_frame;
    int         bidx;
    logic [7:0] bits;
    int         zero_run;
    bit         seen_frame;
    int         done_on, done_off;
    int         ack_due, cmp_due;
    bit         due_err, err_exp;
    logic [3:0] cur_delay;
    int         mode;      // 0 random, 1 pulse after fixed_k, 2 hold through SEND, 3 never done
    int         fixed_k;
    int         last_start;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        in_frame   = 0;
        bidx       = 0;
        zero_run   = 0;
        seen_frame = 0;
        done_on    = -1000;
        done_off   = -1000;
        ack_due    = -1;
        cmp_due    = -1;
        due_err    = 0;
        err_exp    = 0;
        cur_delay  = '0;
        timer_done = 1'b0;
    endtask

    // Frame start seen at cycle s; last bit lands at b = s+7, WAIT_DONE begins there.
    task automatic schedule(input int s);
        int b;
        int m;
        b = s + 7;
        m = mode;
        if (m == 0) m = ($urandom_range(0, 3) == 0) ? 2 : 1;
        due_err = 0;
        cmp_due = -1;
        if (m == 1) begin
            done_on  = b + ((mode == 1) ? fixed_k : int'($urandom_range(0, 4)));
            done_off = done_on + 1;
            ack_due  = done_on + 1;
        end else if (m == 2) begin
            done_on  = s;
            done_off = b + 4;
            ack_due  = b + 1;
        end else begin
            done_on  = -1000;
            done_off = -1000;
            ack_due  = -1;
`ifdef TIMER_CMD_WDOG_EN
            cmp_due  = b + TMO;
            due_err  = 1;
`endif
        end
    endtask

    task automatic monitor();
        if (n == cmp_due && due_err) err_exp = 1;
        check("timer_ack", timer_ack, n == ack_due);
        check("cmp_valid", cmp_valid, (n == ack_due) || (n == cmp_due));
        if (cmp_valid) begin
            check("cmp_delay", cmp_delay, cur_delay);
            check("cmp_err", cmp_err, due_err && (n == cmp_due));
        end
        check("err_timeout", err_timeout, err_exp);
        if (in_frame) begin
            bits[7-bidx] = ser_data;
            bidx++;
            if (bidx == 8) begin
                in_frame = 0;
                zero_run = 0;
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", 1, 0);
                end else begin
                    cur_delay = exp_q.pop_front();
                    check("frame_bits", bits, {4'b1101, cur_delay});
                end
            end
        end else if (ser_data) begin
            if (seen_frame) check("gap_zeros", zero_run >= 7, 1);
            seen_frame = 1;
            in_frame   = 1;
            bidx       = 1;
            bits       = 8'h80;
            last_start = n;
            schedule(n);
        end else begin
            zero_run++;
        end
    endtask

    task automatic cycle();
        bit fire;
        fire = req_valid && req_ready && !reset;
        @(posedge clk);
        #1;
        n++;
        if (fire) begin
            exp_q.push_back(req_delay);
            pushes++;
        end
        monitor();
        timer_done = (n >= done_on) && (n < done_off);
    endtask

    task automatic drain();
        for (int i = 0; i < 600 && (exp_q.size() != 0 || in_frame || busy); i++) cycle();
        repeat (3) cycle();
        check("drained", (exp_q.size() == 0) && !busy, 1);
    endtask

    task automatic push_one(input logic [3:0] d);
        req_valid = 1'b1;
        req_delay = d;
        cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        int t0;
        int p0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_delay  = '0;
        mode       = 0;
        fixed_k    = 0;
        last_start = -1;
        clear_model();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ser_data", ser_data, 0);
        check("rst_timer_ack", timer_ack, 0);
        check("rst_cmp_valid", cmp_valid, 0);
        check("rst_cmp_delay", cmp_delay, 0);
        check("rst_cmp_err", cmp_err, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        reset = 1'b0;

        // Single command 0101, done pulsed 20 cycles after the push edge.
        mode    = 1;
        fixed_k = 11;
        push_one(4'b0101);
        t0 = n;
        repeat (30) cycle();
        check("first_bit_latency", last_start, t0 + 2);
        check("idle_after_cmd", busy, 0);

        // Continuous valid while the first command is in SEND: DEPTH+1 accepted.
        mode = 0;
        p0   = pushes;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_delay = 4'($urandom);
            cycle();
        end
        req_valid = 1'b0;
        check("fill_accepted", pushes - p0, DEPTH + 1);
        check("full_ready_low", req_ready, 0);
        drain();

        // Done held high through SEND: ack only on the first WAIT_DONE cycle.
        mode = 2;
        push_one(4'h9);
        drain();

        // 1111 then 0000 back-to-back.
        mode    = 1;
        fixed_k = 0;
        push_one(4'b1111);
        push_one(4'b0000);
        drain();

        // Reset in the middle of SEND aborts silently.
        mode = 0;
        push_one(4'hA);
        for (int i = 0; i < 20 && !(in_frame && bidx == 4); i++) cycle();
        check("reached_send", in_frame && bidx == 4, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n++;
        check("midrst_ser_data", ser_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmp_valid", cmp_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        reset = 1'b0;
        clear_model();
        repeat (30) cycle();

`ifdef TIMER_CMD_WDOG_EN
        // Timer never answers: watchdog completion with error, no ack.
        mode = 3;
        push_one(4'h6);
        for (int i = 0; i < 120 && busy; i++) cycle();
        check("wdog_err_sticky", err_timeout, 1);
        mode    = 1;
        fixed_k = 2;
        push_one(4'h3);
        drain();
`endif

        // Random traffic with random timer response times.
        mode = 0;
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_delay = 4'($urandom);
            cycle();
        end
        req_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
